// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares one single-write / dual-read register file between
// NREQ requesters. Round-robin grant, one op per cycle, optional lock that
// keeps the grant with one requester for atomic sequences (forcibly released
// after LOCK_TO idle cycles). Read data returns one cycle after acceptance,
// matching the register file's synchronous read.
//
// Optional feature macro: RF_WBYPASS_EN
//   defined   -> an op that reads the register it writes gets the NEW value
//   undefined -> such an op gets the OLD value (plain register file timing)
module regfile_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int LOCK_TO = 15
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_ra1,
  input  logic [NREQ*AW-1:0] req_ra2,
  input  logic [NREQ*AW-1:0] req_wa,
  input  logic [NREQ*DW-1:0] req_wd,
  output logic [NREQ-1:0]    resp_valid,
  output logic [DW-1:0]      resp_rd1,
  output logic [DW-1:0]      resp_rd2,
  output logic               rf_write,
  output logic [AW-1:0]      rf_readReg1,
  output logic [AW-1:0]      rf_readReg2,
  output logic [AW-1:0]      rf_writeReg,
  output logic [DW-1:0]      rf_writeData,
  input  logic [DW-1:0]      rf_readData1,
  input  logic [DW-1:0]      rf_readData2
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;
  localparam logic [CW-1:0] IDLE_MAX = CW'(LOCK_TO - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   owner_r;
  logic [CW-1:0]   idle_cnt_r;
  logic [NREQ-1:0] resp_valid_r;

  logic            grant_vld_s;
  logic [PW-1:0]   grant_idx_s;
  logic [PW-1:0]   cand_s;
  logic [NREQ-1:0] ready_s;
  logic            accept_s;
  logic            grant_lock_s;
  logic            grant_we_s;
  logic [AW-1:0]   sel_ra1_s;
  logic [AW-1:0]   sel_ra2_s;
  logic [AW-1:0]   sel_wa_s;
  logic [DW-1:0]   sel_wd_s;
  logic [DW-1:0]   resp_rd1_s;
  logic [DW-1:0]   resp_rd2_s;

  // Round-robin successor of a requester index.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
    logic [PW-1:0] r;
    if (int'(g) >= NREQ - 1) begin
      r = '0;
    end else begin
      r = g + PW'(1);
    end
    return r;
  endfunction

  // One-hot vector for a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] g);
    logic [NREQ-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) begin
      r[i] = (g == PW'(i));
    end
    return r;
  endfunction

  // Grant selection: round-robin from ptr when idle, owner only when locked.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    if (!resetn) begin
      grant_vld_s = 1'b0;
    end else if (state_r == ST_LOCKED) begin
      grant_vld_s = req_valid[owner_r];
      grant_idx_s = owner_r;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cand_s = PW'((int'(ptr_r) + k) % NREQ);
        if (!grant_vld_s && req_valid[cand_s]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = cand_s;
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end
  end

  // Ready vector (doubles as the accept one-hot) and granted-slice mux.
  always_comb begin
    ready_s      = grant_vld_s ? onehot(grant_idx_s) : '0;
    sel_ra1_s    = '0;
    sel_ra2_s    = '0;
    sel_wa_s     = '0;
    sel_wd_s     = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_ra1_s = sel_ra1_s | (req_ra1[i*AW +: AW] & {AW{ready_s[i]}});
      sel_ra2_s = sel_ra2_s | (req_ra2[i*AW +: AW] & {AW{ready_s[i]}});
      sel_wa_s  = sel_wa_s  | (req_wa[i*AW +: AW]  & {AW{ready_s[i]}});
      sel_wd_s  = sel_wd_s  | (req_wd[i*DW +: DW]  & {DW{ready_s[i]}});
    end
    accept_s     = |ready_s;
    grant_lock_s = |(ready_s & req_lock);
    grant_we_s   = |(ready_s & req_we);
  end

  assign req_ready    = ready_s;
  assign rf_write     = accept_s & grant_we_s;
  assign rf_readReg1  = sel_ra1_s;
  assign rf_readReg2  = sel_ra2_s;
  assign rf_writeReg  = sel_wa_s;
  assign rf_writeData = sel_wd_s;

  // Arbitration state: pointer, lock ownership, lock timeout, response flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      ptr_r        <= '0;
      owner_r      <= '0;
      idle_cnt_r   <= '0;
      resp_valid_r <= '0;
    end else begin
      resp_valid_r <= ready_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s && grant_lock_s) begin
            state_r    <= ST_LOCKED;
            owner_r    <= grant_idx_s;
            idle_cnt_r <= '0;
          end else if (accept_s) begin
            ptr_r <= next_ptr(grant_idx_s);
          end else begin
            ptr_r <= ptr_r;
          end
        end
        ST_LOCKED: begin
          if (accept_s && grant_lock_s) begin
            idle_cnt_r <= '0;
          end else if (accept_s) begin
            state_r    <= ST_IDLE;
            ptr_r      <= next_ptr(owner_r);
            idle_cnt_r <= '0;
          end else if (idle_cnt_r == IDLE_MAX) begin
            // owner went quiet too long: drop the lock so others can proceed
            state_r    <= ST_IDLE;
            ptr_r      <= next_ptr(owner_r);
            idle_cnt_r <= '0;
          end else begin
            idle_cnt_r <= idle_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          idle_cnt_r <= '0;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_r;

`ifdef RF_WBYPASS_EN
  logic          byp1_r;
  logic          byp2_r;
  logic [DW-1:0] byp_wd_r;

  // Capture same-op read-after-write matches so the response returns new data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byp1_r   <= 1'b0;
      byp2_r   <= 1'b0;
      byp_wd_r <= '0;
    end else begin
      byp1_r   <= accept_s & grant_we_s & (sel_ra1_s == sel_wa_s);
      byp2_r   <= accept_s & grant_we_s & (sel_ra2_s == sel_wa_s);
      byp_wd_r <= sel_wd_s;
    end
  end
`endif

  // Response data: register-file read data (or bypass) only in the response cycle.
  always_comb begin
    resp_rd1_s = '0;
    resp_rd2_s = '0;
    if (|resp_valid_r) begin
`ifdef RF_WBYPASS_EN
      resp_rd1_s = byp1_r ? byp_wd_r : rf_readData1;
      resp_rd2_s = byp2_r ? byp_wd_r : rf_readData2;
`else
      resp_rd1_s = rf_readData1;
      resp_rd2_s = rf_readData2;
`endif
    end else begin
      resp_rd1_s = '0;
      resp_rd2_s = '0;
    end
  end

  assign resp_rd1 = resp_rd1_s;
  assign resp_rd2 = resp_rd2_s;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Table-driven bench for regfile_arbiter (NREQ=2, LOCK_TO=4) with a simple
// synchronous-read register file model hanging off the rf_* ports.
module tb_regfile_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk;
  logic               resetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_ra1;
  logic [NREQ*AW-1:0] req_ra2;
  logic [NREQ*AW-1:0] req_wa;
  logic [NREQ*DW-1:0] req_wd;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_rd1;
  logic [DW-1:0]      resp_rd2;
  logic               rf_write;
  logic [AW-1:0]      rf_readReg1;
  logic [AW-1:0]      rf_readReg2;
  logic [AW-1:0]      rf_writeReg;
  logic [DW-1:0]      rf_writeData;
  logic [DW-1:0]      rf_readData1;
  logic [DW-1:0]      rf_readData2;

  int checks;
  int errors;

`ifdef RF_WBYPASS_EN
  localparam logic [31:0] EXP_SAME_OP = 32'h0000_0055;
`else
  localparam logic [31:0] EXP_SAME_OP = 32'h0000_0000;
`endif

  regfile_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_TO(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_we(req_we), .req_ra1(req_ra1), .req_ra2(req_ra2),
    .req_wa(req_wa), .req_wd(req_wd),
    .resp_valid(resp_valid), .resp_rd1(resp_rd1), .resp_rd2(resp_rd2),
    .rf_write(rf_write), .rf_readReg1(rf_readReg1), .rf_readReg2(rf_readReg2),
    .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
    .rf_readData1(rf_readData1), .rf_readData2(rf_readData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: synchronous read, write on the same edge (read sees old).
  logic [DW-1:0] regs [32];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < 32; r++) regs[r] <= 32'd0;
      rf_readData1 <= 32'd0;
      rf_readData2 <= 32'd0;
    end else begin
      if (rf_write) regs[rf_writeReg] <= rf_writeData;
      rf_readData1 <= regs[rf_readReg1];
      rf_readData2 <= regs[rf_readReg2];
    end
  end

  typedef struct packed {
    logic [1:0]  valid;
    logic [1:0]  lock;
    logic [1:0]  we;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [1:0]  exp_ready;
    logic        exp_rfw;
    logic [4:0]  exp_rra;
    logic [1:0]  exp_rvalid;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    req_valid = v.valid;
    req_lock  = v.lock;
    req_we    = v.we;
    req_ra1   = {v.ra1, v.ra0};
    req_ra2   = {v.ra1, v.ra0};
    req_wa    = {5'd0, v.wa0};
    req_wd    = {32'd0, v.wd0};
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // grant alternation, both requesters valid, no lock
    tbl[0]  = '{2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 5'd0, 32'h0, 2'b01, 1'b0, 5'd1, 2'b00, 32'h0};
    tbl[1]  = '{2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 5'd0, 32'h0, 2'b10, 1'b0, 5'd2, 2'b01, 32'h0};
    tbl[2]  = '{2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 5'd0, 32'h0, 2'b01, 1'b0, 5'd1, 2'b10, 32'h0};
    tbl[3]  = '{2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 5'd0, 32'h0, 2'b10, 1'b0, 5'd2, 2'b01, 32'h0};
    tbl[4]  = '{2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 5'd0, 32'h0, 2'b01, 1'b0, 5'd1, 2'b10, 32'h0};
    tbl[5]  = '{2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 5'd0, 32'h0, 2'b10, 1'b0, 5'd2, 2'b01, 32'h0};
    // req0 writes r5, req1 reads r5 next cycle
    tbl[6]  = '{2'b01, 2'b00, 2'b01, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 2'b01, 1'b1, 5'd0, 2'b10, 32'h0};
    tbl[7]  = '{2'b10, 2'b00, 2'b00, 5'd0, 5'd5, 5'd0, 32'h0, 2'b10, 1'b0, 5'd5, 2'b01, 32'h0};
    tbl[8]  = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 2'b10, 32'hDEADBEEF};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 2'b00, 32'h0};
    // req1 holds a 3-op lock while req0 keeps asking
    tbl[10] = '{2'b11, 2'b00, 2'b00, 5'd3, 5'd4, 5'd0, 32'h0, 2'b01, 1'b0, 5'd3, 2'b00, 32'h0};
    tbl[11] = '{2'b11, 2'b10, 2'b00, 5'd3, 5'd4, 5'd0, 32'h0, 2'b10, 1'b0, 5'd4, 2'b01, 32'h0};
    tbl[12] = '{2'b11, 2'b10, 2'b00, 5'd3, 5'd4, 5'd0, 32'h0, 2'b10, 1'b0, 5'd4, 2'b10, 32'h0};
    tbl[13] = '{2'b11, 2'b00, 2'b00, 5'd3, 5'd4, 5'd0, 32'h0, 2'b10, 1'b0, 5'd4, 2'b10, 32'h0};
    tbl[14] = '{2'b11, 2'b00, 2'b00, 5'd3, 5'd4, 5'd0, 32'h0, 2'b01, 1'b0, 5'd3, 2'b10, 32'h0};
    // req1 locks then goes quiet: lock times out after 4 idle cycles
    tbl[15] = '{2'b10, 2'b10, 2'b00, 5'd3, 5'd4, 5'd0, 32'h0, 2'b10, 1'b0, 5'd4, 2'b01, 32'h0};
    tbl[16] = '{2'b01, 2'b00, 2'b00, 5'd3, 5'd4, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 2'b10, 32'h0};
    tbl[17] = '{2'b01, 2'b00, 2'b00, 5'd3, 5'd4, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 2'b00, 32'h0};
    tbl[18] = '{2'b01, 2'b00, 2'b00, 5'd3, 5'd4, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 2'b00, 32'h0};
    tbl[19] = '{2'b01, 2'b00, 2'b00, 5'd3, 5'd4, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 2'b00, 32'h0};
    tbl[20] = '{2'b11, 2'b00, 2'b00, 5'd3, 5'd4, 5'd0, 32'h0, 2'b01, 1'b0, 5'd3, 2'b00, 32'h0};
    tbl[21] = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 2'b01, 32'h0};

    // reset state with requests pending
    resetn    = 1'b0;
    req_valid = 2'b11;
    req_lock  = 2'b00;
    req_we    = 2'b11;
    req_ra1   = '0;
    req_ra2   = '0;
    req_wa    = '0;
    req_wd    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rfw", 32'(rf_write), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);

    // one op from req0, then reset during its response cycle
    resetn    = 1'b1;
    req_valid = 2'b01;
    req_we    = 2'b00;
    #1;
    chk("t1_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("t1_rvalid", 32'(resp_valid), 32'd1);
    #2;
    resetn    = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b11;
    #1;
    chk("t1_rst_rvalid", 32'(resp_valid), 32'd0);
    chk("t1_rst_rfw", 32'(rf_write), 32'd0);
    chk("t1_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    resetn    = 1'b1;
    req_valid = 2'b00;
    req_we    = 2'b00;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("v%0d_rfw", i), 32'(rf_write), 32'(tbl[i].exp_rfw));
      chk($sformatf("v%0d_rra1", i), 32'(rf_readReg1), 32'(tbl[i].exp_rra));
      chk($sformatf("v%0d_rvalid", i), 32'(resp_valid), 32'(tbl[i].exp_rvalid));
      chk($sformatf("v%0d_rd1", i), resp_rd1, tbl[i].exp_rd);
      chk($sformatf("v%0d_rd2", i), resp_rd2, tbl[i].exp_rd);
      if (tbl[i].exp_ready == 2'b00) begin
        chk($sformatf("v%0d_wd_idle", i), rf_writeData, 32'd0);
      end
      @(posedge clk);
      #1;
    end

    // same-op read of the register being written (r7 currently 0)
    req_valid = 2'b01;
    req_lock  = 2'b00;
    req_we    = 2'b01;
    req_ra1   = {5'd0, 5'd7};
    req_ra2   = {5'd0, 5'd7};
    req_wa    = {5'd0, 5'd7};
    req_wd    = {32'd0, 32'h0000_0055};
    @(negedge clk);
    chk("t6_rfw", 32'(rf_write), 32'd1);
    chk("t6_wreg", 32'(rf_writeReg), 32'd7);
    chk("t6_wdata", rf_writeData, 32'h0000_0055);
    @(posedge clk);
    #1;
    req_we = 2'b00;
    @(negedge clk);
    chk("t6_rvalid", 32'(resp_valid), 32'd1);
    chk("t6_same_rd1", resp_rd1, EXP_SAME_OP);
    chk("t6_same_rd2", resp_rd2, EXP_SAME_OP);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("t6_next_rvalid", 32'(resp_valid), 32'd1);
    chk("t6_next_rd1", resp_rd1, 32'h0000_0055);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
Shares the single-write, dual-read 32x32 register file between NREQ requesters (e.g. core pipeline and debug/loader port) with a valid/ready request handshake. One operation per cycle, round-robin grant, optional multi-cycle lock for atomic sequences. The block drives the register file ports directly and returns read data to the winning requester one cycle after acceptance, matching the register file's 1-cycle synchronous read.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 5, register address width
DW, 32, data width
LOCK_TO, 15, idle cycles before a lock is forcibly released (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  NREQ  request present, bit i = requester i
req_ready  out  NREQ  grant; at most one bit set
req_lock  in  NREQ  keep grant after this op
req_we  in  NREQ  op includes a write
req_ra1  in  NREQ*AW  read address 1, slice i = requester i
req_ra2  in  NREQ*AW  read address 2
req_wa  in  NREQ*AW  write address
req_wd  in  NREQ*DW  write data
resp_valid  out  NREQ  one-hot, read data valid for that requester
resp_rd1  out  DW  read data 1
resp_rd2  out  DW  read data 2
rf_write  out  1  to register file write
rf_readReg1  out  AW  to register file readReg1
rf_readReg2  out  AW  to register file readReg2
rf_writeReg  out  AW  to register file writeReg
rf_writeData  out  DW  to register file writeData
rf_readData1  in  DW  from register file readData1
rf_readData2  in  DW  from register file readData2

Behaviour:
- Reset (async, resetn=0): ptr=0, state=IDLE, owner=0, idle_cnt=0, resp_valid=0. Pending response dropped; held lock released. req_ready, rf_write=0 while in reset.
- Accept = req_valid[i] & req_ready[i]. req_ready combinational from req_valid and state; never depends on req_ready feedback.
- IDLE: grant g = first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NREQ. No valid -> no grant, req_ready=0.
- On accept in IDLE: req_lock[g]=0 -> ptr<=(g+1) mod NREQ; req_lock[g]=1 -> state<=LOCKED, owner<=g, idle_cnt<=0.
- LOCKED: only owner may be granted (req_ready[owner]=req_valid[owner]); all other ready bits 0.
  - Owner accept with req_lock=0 -> IDLE, ptr<=(owner+1) mod NREQ.
  - Owner accept with req_lock=1 -> stay, idle_cnt<=0.
  - Owner not valid -> idle_cnt+1; when idle_cnt reaches LOCK_TO-1 (LOCK_TO idle cycles) -> IDLE, ptr<=(owner+1) mod NREQ, idle_cnt<=0.
- RF drive (combinational, same cycle as accept): rf_readReg1/2, rf_writeReg, rf_writeData = granted slices; all zero when no grant. rf_write = accept & req_we[g]; never 1 without accept.
- Response: resp_valid<=onehot(g) on accept (every op, including write-only), else 0. Latency: accept at edge k -> resp_valid high for exactly cycle after edge k. resp_rd1/2 = rf_readData1/2 when resp_valid!=0, else 0.
- No response backpressure; requesters must take resp in its cycle.
- Hazard: op reading and writing same address gets OLD value (register file read/write same edge). Op accepted next cycle sees new value. No address-0 special case.
- Back-to-back accepts every cycle supported; throughput 1 op/cycle.

Optional Feature:
RF_WBYPASS_EN: defined -> on accept, register byp1=(we & ra1==wa), byp2=(we & ra2==wa), and wd; during response cycle resp_rdN=captured wd when bypN=1, so a same-op read of the written register returns NEW data. Undefined -> no extra registers, old-value behaviour above.

Test Plan:
1. Reset asserted mid-response (resp_valid=2'b01) -> resp_valid=0, rf_write=0 immediately; after release both valid -> req0 granted first.
2. Both valid, lock=0, 6 cycles -> grant sequence 0,1,0,1,0,1; resp_valid 01,10,01,... lagging one cycle.
3. req0 writes r5=0xDEADBEEF; next cycle req1 reads ra1=5 -> rf_write=1 then 0; resp_valid=2'b10 with resp_rd1=0xDEADBEEF.
4. req1 accepted with lock=1 for 3 ops (last lock=0) while req0 continuously valid -> req_ready[0]=0 for those 3 cycles, req0 granted on 4th.
5. LOCK_TO=4: req1 locks then drops valid, req0 valid -> req0 granted exactly after 4 idle cycles; ptr then favours req0.
6. r7=0, one op we=1 wa=7 wd=0x55 ra1=7 -> resp_rd1=0 without RF_WBYPASS_EN, 0x55 with it; following read of r7 -> 0x55 in both.
